// File: rtl/key_pkg.sv
// Shared types and defaults for the key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50_000;
  localparam int LONG_CYCLES_DEF     = 1_500_000;

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM and, when
// KEY_LONG_PRESS_EN is defined, the long-press counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  key_state_t      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Synchronizer feed and debounce next-state logic.
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = {DB_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_DB: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = {DB_W{1'b0}};
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_RELEASE_DB: begin
        if (sync2_q) begin
          state_d = ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = {DB_W{1'b0}};
        level_d  = 1'b0;
      end
    endcase
  end

  // Synchronizer, FSM and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      db_cnt_q  <= {DB_W{1'b0}};
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int              LG_W    = cnt_width(LONG_CYCLES);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

  logic [LG_W-1:0] long_cnt_q, long_cnt_d;
  logic            long_done_q, long_done_d;
  logic            long_q, long_d;

  // Long-press counter; a release in the firing cycle wins so events never overlap.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (press_d) begin
      long_cnt_d  = {LG_W{1'b0}};
      long_done_d = 1'b0;
    end else if (state_q == ST_HELD || state_q == ST_RELEASE_DB) begin
      if (long_cnt_q != LG_LAST) begin
        long_cnt_d = long_cnt_q + LG_W'(1);
      end else if (!long_done_q && !release_d) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        long_d = 1'b0;
      end
    end else begin
      long_d = 1'b0;
    end
  end

  // Long-press registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q  <= {LG_W{1'b0}};
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer top: one independent channel per key.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [N_KEYS-1:0] Key,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release,
  output logic [N_KEYS-1:0] Key_Long
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (Sys_CLK),
      .rst_n      (Sys_RST),
      .key_raw    (Key[g]),
      .key_level  (Key_Level[g]),
      .key_press  (Key_Press[g]),
      .key_release(Key_Release[g]),
      .key_long   (Key_Long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;
  localparam int N = 2;
  localparam int D = 8;
  localparam int L = 32;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key   = '0;
  logic [N-1:0] lvl, prs, rel, lng;

  always #10 clk = ~clk;

  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .Sys_CLK(clk), .Sys_RST(rst_n), .Key(key),
    .Key_Level(lvl), .Key_Press(prs), .Key_Release(rel), .Key_Long(lng)
  );

  // Reference model: a level change is accepted once the input seen two
  // edges late has held the new value for D+1 consecutive edges; long
  // fires L edges after a press if the key stays accepted throughout.
  bit           m_s1 [N];
  bit           m_s2 [N];
  bit           m_rv [N];
  int           m_rl [N];
  int           m_sp [N];
  logic [N-1:0] e_lvl, e_prs, e_rel, e_lng;
  int           checks = 0;
  int           passes = 0;
  int           edge_no = 0;

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_rv[c] = 1'b0; m_rl[c] = 0; m_sp[c] = -1;
    end
    e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    e_prs = '0; e_rel = '0; e_lng = '0;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int c = 0; c < N; c++) begin
        bit s;
        s = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = key[c];
        if (s == m_rv[c]) m_rl[c]++;
        else begin m_rv[c] = s; m_rl[c] = 1; end
        if (s != e_lvl[c] && m_rl[c] >= D + 1) begin
          e_lvl[c] = s;
          if (s) begin e_prs[c] = 1'b1; m_sp[c] = 0; end
          else begin e_rel[c] = 1'b1; m_sp[c] = -1; end
        end else if (m_sp[c] >= 0) begin
          m_sp[c]++;
          if (m_sp[c] == L && LONG_EN) e_lng[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    key = 2'b11;
    #1;
    checks++;
    if ({lvl, prs, rel, lng} !== '0)
      $display("FAIL reset_async: got %b, want 0", {lvl, prs, rel, lng});
    else passes++;
    repeat (4) begin
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL reset_hold edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
    end
    key   = '0;
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_basic();
    int t0, p, lg, r, np, nl, nr;
    p = -1; lg = -1; r = -1; np = 0; nl = 0; nr = 0;
    key[0] = 1'b1;
    t0 = edge_no;
    repeat (100) begin
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL basic_model edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
      if (prs[0]) begin np++; p = edge_no - t0; end
      if (lng[0]) begin nl++; lg = edge_no - t0; end
    end
    checks++;
    if (lvl[0] !== 1'b1) $display("FAIL basic_level: got %b, want 1", lvl[0]);
    else passes++;
    key[0] = 1'b0;
    t0 = edge_no;
    repeat (20) begin
      step();
      if (rel[0]) begin nr++; r = edge_no - t0; end
    end
    checks++;
    if (np !== 1 || p !== D + 3) $display("FAIL basic_press: got count %0d edge %0d, want 1 at %0d", np, p, D + 3);
    else passes++;
    checks++;
    if (nl !== (LONG_EN ? 1 : 0) || lg !== (LONG_EN ? p + L : -1))
      $display("FAIL basic_long: got count %0d edge %0d, want %0d at %0d", nl, lg, LONG_EN ? 1 : 0, LONG_EN ? p + L : -1);
    else passes++;
    checks++;
    if (nr !== 1 || r !== D + 3) $display("FAIL basic_release: got count %0d edge %0d, want 1 at %0d", nr, r, D + 3);
    else passes++;
  endtask

  task automatic test_bounce();
    int ev;
    logic lv;
    ev = 0; lv = 1'b0;
    for (int i = 0; i < 32; i++) begin
      key[0] = (i < 12) ? ~i[1] : 1'b0;
      if (i < 12) key[0] = ((i / 3) % 2 == 0);
      step();
      ev += int'(prs[0]) + int'(rel[0]) + int'(lng[0]);
      lv |= lvl[0];
    end
    checks++;
    if (ev !== 0 || lv !== 1'b0) $display("FAIL bounce: got %0d events level %b, want 0 and 0", ev, lv);
    else passes++;
  endtask

  task automatic test_simultaneous();
    int t0, p, nl;
    p = -1; nl = 0;
    key = 2'b11;
    t0 = edge_no;
    repeat (20) begin
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL simul_model edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
      if (prs == 2'b11) p = edge_no - t0;
      nl += int'(lng[0]) + int'(lng[1]);
    end
    key = 2'b00;
    repeat (20) begin step(); nl += int'(lng[0]) + int'(lng[1]); end
    checks++;
    if (p !== D + 3 || nl !== 0) $display("FAIL simul: got press edge %0d longs %0d, want %0d and 0", p, nl, D + 3);
    else passes++;
  endtask

  task automatic test_dropout();
    int np, nr_mid, nr_end;
    np = 0; nr_mid = 0; nr_end = 0;
    for (int i = 0; i < 42; i++) begin
      key[1] = !(i == 20 || i == 21);
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL dropout_model edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
      np += int'(prs[1]);
      nr_mid += int'(rel[1]);
    end
    key[1] = 1'b0;
    repeat (15) begin step(); nr_end += int'(rel[1]); end
    checks++;
    if (np !== 1 || nr_mid !== 0 || nr_end !== 1)
      $display("FAIL dropout: got press %0d rel_mid %0d rel_end %0d, want 1 0 1", np, nr_mid, nr_end);
    else passes++;
  endtask

  task automatic test_reset_held();
    int t0, p;
    p = -1;
    key[0] = 1'b1;
    repeat (15) step();
    checks++;
    if (lvl[0] !== 1'b1) $display("FAIL rst_held_pre: got %b, want 1", lvl[0]);
    else passes++;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({lvl, prs, rel, lng} !== '0) $display("FAIL rst_held_async: got %b, want 0", {lvl, prs, rel, lng});
    else passes++;
    repeat (3) begin
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== '0) $display("FAIL rst_held_during edge %0d: got %b, want 0", edge_no, {lvl, prs, rel, lng});
      else passes++;
    end
    rst_n = 1'b1;
    t0 = edge_no;
    repeat (20) begin
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL rst_held_model edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
      if (prs[0] && p < 0) p = edge_no - t0;
    end
    checks++;
    if (p !== D + 3) $display("FAIL rst_held_repress: got edge %0d, want %0d", p, D + 3);
    else passes++;
    key[0] = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_random();
    int hold [N];
    for (int c = 0; c < N; c++) hold[c] = 0;
    repeat (900) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          key[c]  = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60)) : int'($urandom_range(1, 12));
        end
        hold[c]--;
      end
      step();
      checks++;
      if ({lvl, prs, rel, lng} !== {e_lvl, e_prs, e_rel, e_lng})
        $display("FAIL random_model edge %0d: got %b, want %b", edge_no, {lvl, prs, rel, lng}, {e_lvl, e_prs, e_rel, e_lng});
      else passes++;
      checks++;
      if (((prs & rel) | (prs & lng) | (rel & lng)) !== '0)
        $display("FAIL random_exclusive edge %0d: got prs=%b rel=%b lng=%b, want no overlap", edge_no, prs, rel, lng);
      else passes++;
    end
    key = '0;
    repeat (15) step();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_bounce();
    test_simultaneous();
    test_dropout();
    test_reset_held();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
